// File: rtl/muldiv_sequencer_pkg.sv
// muldiv_sequencer_pkg
// Shared definitions for the RV32M multiply/divide sequencer: the operation
// encoding (matches the funct3 field of the M-extension opcodes), the default
// datapath width, the iteration count and a few operation-class helpers.
// No ports; imported by muldiv_sequencer and its testbench.
package muldiv_sequencer_pkg;

  localparam int MULDIV_DATA_WIDTH = 32;
  localparam int MULDIV_ITER = MULDIV_DATA_WIDTH;
  localparam logic [31:0] MULDIV_OVF_DIVIDEND = 32'h8000_0000;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_type;

  // Any of the four divide-family operations.
  function automatic logic opIsDiv(input muldiv_op_type op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  // Divide operations that return the remainder rather than the quotient.
  function automatic logic opIsRem(input muldiv_op_type op);
    return op inside {OP_REM, OP_REMU};
  endfunction

  // rs1 is treated as two's complement.
  function automatic logic opASigned(input muldiv_op_type op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  // rs2 is treated as two's complement (MULHSU keeps rs2 unsigned).
  function automatic logic opBSigned(input muldiv_op_type op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/muldiv_sequencer_div_step.sv
// div_step
// One combinational iteration of an unsigned restoring divider.
// The running remainder is shifted left with the next dividend bit; if the
// divisor fits, it is subtracted and the quotient bit is 1.
// Ports:
//   rem_i      current remainder (always < divisor)
//   bit_i      next dividend bit, MSB first
//   divisor_i  divisor magnitude
//   rem_o      remainder after this step
//   qbit_o     quotient bit produced by this step
module div_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rem_i,
  input  logic                  bit_i,
  input  logic [DATA_WIDTH-1:0] divisor_i,
  output logic [DATA_WIDTH-1:0] rem_o,
  output logic                  qbit_o
);

  logic [DATA_WIDTH:0]   shifted;
  logic [DATA_WIDTH-1:0] diff;

  // The shifted remainder can need one extra bit, but whenever the divisor
  // fits the true difference is below the divisor, so a modulo-2^W subtract
  // on the low bits gives the exact new remainder.
  always_comb begin
    shifted = {rem_i, bit_i};
    qbit_o  = (shifted >= {1'b0, divisor_i});
    diff    = shifted[DATA_WIDTH-1:0] - divisor_i;
    rem_o   = qbit_o ? diff : shifted[DATA_WIDTH-1:0];
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
// Multi-cycle RV32M unit beside the execute-stage ALU. Accepts one op,
// stalls the pipeline while a radix-2 shift-add multiply or restoring divide
// runs one bit per cycle, then presents a registered result with a one-cycle
// done pulse. Divide-by-zero and signed overflow complete on a fast path.
// Ports:
//   clk, rst   clock and asynchronous active-high reset
//   i_valid    execute holds an M op (held stable while o_stall=1)
//   i_op       operation (funct3 encoding)
//   i_a, i_b   rs1 / rs2 operands after forwarding
//   i_flush    kill any in-flight or offered op
//   o_stall    freeze the pipeline (combinational)
//   o_done     one-cycle pulse, o_result valid
//   o_result   registered result, held until the next done
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = MULDIV_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  input  muldiv_op_type         i_op,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  input  logic                  i_flush,
  output logic                  o_stall,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_result
);

  localparam int CntW = $clog2(DATA_WIDTH + 1);
  localparam logic [DATA_WIDTH-1:0] OvfDividend = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t                state_q;
  logic [CntW-1:0]       cnt_q;
  muldiv_op_type         op_q;
  logic                  neg_q;
  logic [DATA_WIDTH-1:0] accHi_q;
  logic [DATA_WIDTH-1:0] accLo_q;
  logic [DATA_WIDTH-1:0] operand_q;
  logic                  done_q;
  logic [DATA_WIDTH-1:0] result_q;

  logic                  signA;
  logic                  signB;
  logic [DATA_WIDTH-1:0] magA;
  logic [DATA_WIDTH-1:0] magB;
  logic                  inIsDiv;
  logic                  inIsRem;
  logic                  divZero;
  logic                  divOvf;
  logic [DATA_WIDTH-1:0] fastResult;

  logic [DATA_WIDTH:0]     mulSum;
  logic [DATA_WIDTH-1:0]   divRem;
  logic                    divQbit;
  logic [DATA_WIDTH-1:0]   accHi_d;
  logic [DATA_WIDTH-1:0]   accLo_d;
  logic [2*DATA_WIDTH-1:0] product;
  logic [2*DATA_WIDTH-1:0] productFix;
  logic [DATA_WIDTH-1:0]   divVal;
  logic [DATA_WIDTH-1:0]   divFix;
  logic [DATA_WIDTH-1:0]   finalResult;

  // Operand conditioning for a newly offered op: magnitudes, signs and the
  // two RISC-V corner cases that bypass the iterative datapath.
  always_comb begin
    inIsDiv = opIsDiv(i_op);
    inIsRem = opIsRem(i_op);
    signA   = opASigned(i_op) & i_a[DATA_WIDTH-1];
    signB   = opBSigned(i_op) & i_b[DATA_WIDTH-1];
    magA    = signA ? -i_a : i_a;
    magB    = signB ? -i_b : i_b;
    divZero = inIsDiv && (i_b == '0);
    divOvf  = inIsDiv && opASigned(i_op) && (i_a == OvfDividend) && (i_b == '1);
    fastResult = '0;
    if (divZero) begin
      fastResult = inIsRem ? i_a : '1;
    end else if (divOvf) begin
      fastResult = inIsRem ? '0 : OvfDividend;
    end
  end

  div_step #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_div_step (
    .rem_i    (accHi_q),
    .bit_i    (accLo_q[DATA_WIDTH-1]),
    .divisor_i(operand_q),
    .rem_o    (divRem),
    .qbit_o   (divQbit)
  );

  // One iteration of whichever datapath is active. The accumulator pair is
  // shared: for multiply accHi:accLo is the product with the multiplier
  // shifting out of accLo; for divide accHi is the remainder and accLo holds
  // the dividend shifting out of the top while quotient bits enter the bottom.
  always_comb begin
    mulSum = {1'b0, accHi_q} + {1'b0, (accLo_q[0] ? operand_q : '0)};
    if (opIsDiv(op_q)) begin
      accHi_d = divRem;
      accLo_d = {accLo_q[DATA_WIDTH-2:0], divQbit};
    end else begin
      accHi_d = mulSum[DATA_WIDTH:1];
      accLo_d = {mulSum[0], accLo_q[DATA_WIDTH-1:1]};
    end
  end

  // Sign fix-up and word select, evaluated on the final iteration so the
  // result register loads on the same edge that enters DONE.
  always_comb begin
    product     = {accHi_d, accLo_d};
    productFix  = neg_q ? -product : product;
    divVal      = opIsRem(op_q) ? accHi_d : accLo_d;
    divFix      = neg_q ? -divVal : divVal;
    finalResult = productFix[2*DATA_WIDTH-1:DATA_WIDTH];
    if (opIsDiv(op_q)) begin
      finalResult = divFix;
    end else if (op_q == OP_MUL) begin
      finalResult = productFix[DATA_WIDTH-1:0];
    end
  end

  // Sequencer. Flush outranks everything but reset and returns to IDLE
  // without touching the result. DONE never accepts: i_valid there still
  // belongs to the op that just finished.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= OP_MUL;
      neg_q     <= 1'b0;
      accHi_q   <= '0;
      accLo_q   <= '0;
      operand_q <= '0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else if (i_flush) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (i_valid) begin
            op_q      <= i_op;
            neg_q     <= inIsRem ? signA : (signA ^ signB);
            accHi_q   <= '0;
            accLo_q   <= inIsDiv ? magA : magB;
            operand_q <= inIsDiv ? magB : magA;
            if (divZero || divOvf) begin
              result_q <= fastResult;
              done_q   <= 1'b1;
              state_q  <= DONE;
            end else begin
              cnt_q   <= CntW'(DATA_WIDTH);
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          accHi_q <= accHi_d;
          accLo_q <= accLo_d;
          cnt_q   <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            result_q <= finalResult;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Stall must rise in the accept cycle itself, so it is decoded from the
  // current state and inputs rather than registered; reset masks it.
  assign o_stall  = ~rst & (((state_q == IDLE) & i_valid & ~i_flush) | (state_q == RUN));
  assign o_done   = done_q & ~i_flush;
  assign o_result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer
// Directed self-checking bench for muldiv_sequencer: reset values, every
// operation class with hand-computed results, the divide-by-zero and overflow
// fast paths, flush in RUN and IDLE, and reset during an operation.
module tb_muldiv_sequencer;
  import muldiv_sequencer_pkg::*;

  logic          clk;
  logic          rst;
  logic          iValid;
  muldiv_op_type iOp;
  logic [31:0]   iA;
  logic [31:0]   iB;
  logic          iFlush;
  logic          oStall;
  logic          oDone;
  logic [31:0]   oResult;

  int total;
  int bad;

  muldiv_sequencer #(
    .DATA_WIDTH(32)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i_valid (iValid),
    .i_op    (iOp),
    .i_a     (iA),
    .i_b     (iB),
    .i_flush (iFlush),
    .o_stall (oStall),
    .o_done  (oDone),
    .o_result(oResult)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: every check goes through this assertion.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Offers one op in the cycle after the current one and follows it to its
  // done pulse, counting stall cycles and the cycle index of o_done
  // (accept cycle = 0). i_valid stays high through DONE, as the pipeline would.
  task automatic applyStimulus(input string tag, input muldiv_op_type op,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] expRes, input int expStall,
                               input int expDoneCyc);
    int stalls;
    int doneCyc;
    logic [31:0] res;
    stalls  = 0;
    doneCyc = -1;
    res     = '0;
    @(negedge clk);
    iValid = 1'b1;
    iOp    = op;
    iA     = a;
    iB     = b;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (oStall) stalls++;
      if (oDone) begin
        doneCyc = c;
        res     = oResult;
        break;
      end
      @(negedge clk);
    end
    checkOutput({tag, " done_seen"}, 32'(doneCyc >= 0), 32'd1);
    checkOutput({tag, " result"}, res, expRes);
    checkOutput({tag, " stall_cycles"}, 32'(stalls), 32'(expStall));
    checkOutput({tag, " done_cycle"}, 32'(doneCyc), 32'(expDoneCyc));
  endtask

  initial begin
    int doneCount;
    total  = 0;
    bad    = 0;
    rst    = 1'b1;
    iValid = 1'b1;
    iOp    = OP_MUL;
    iA     = 32'd3;
    iB     = 32'd4;
    iFlush = 1'b0;

    // Reset state, with a valid op offered to show reset masks the stall.
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset stall", {31'd0, oStall}, 32'd0);
    checkOutput("reset done", {31'd0, oDone}, 32'd0);
    checkOutput("reset result", oResult, 32'd0);
    @(negedge clk);
    rst    = 1'b0;
    iValid = 1'b0;

    // Multi-cycle multiplies and divides, issued back to back.
    applyStimulus("MUL 7*-3", OP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 33);
    applyStimulus("MULHU -1*-1", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 33);
    applyStimulus("MULH -1*-1", OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33, 33);
    applyStimulus("MULHSU -1*2", OP_MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33, 33);
    applyStimulus("DIV -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 33);
    applyStimulus("REM -7/2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 33);
    applyStimulus("DIVU 100/7", OP_DIVU, 32'd100, 32'd7, 32'd14, 33, 33);

    // Fast paths.
    applyStimulus("DIVU 100/0", OP_DIVU, 32'd100, 32'd0, 32'hFFFF_FFFF, 1, 1);
    applyStimulus("REMU 100/0", OP_REMU, 32'd100, 32'd0, 32'd100, 1, 1);
    applyStimulus("DIV ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1);
    applyStimulus("REM ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, 1);
    applyStimulus("REMU 100/7", OP_REMU, 32'd100, 32'd7, 32'd2, 33, 33);

    // Flush at RUN cycle 10: no done, result keeps the previous value (2).
    @(negedge clk);
    iValid = 1'b1;
    iOp    = OP_MUL;
    iA     = 32'd5;
    iB     = 32'd9;
    repeat (10) @(negedge clk);
    iFlush = 1'b1;
    #1;
    checkOutput("flush run done", {31'd0, oDone}, 32'd0);
    @(negedge clk);
    iFlush = 1'b0;
    iValid = 1'b0;
    #1;
    checkOutput("flush run idle stall", {31'd0, oStall}, 32'd0);
    doneCount = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      if (oDone) doneCount++;
    end
    checkOutput("flush run no done", 32'(doneCount), 32'd0);
    checkOutput("flush run result", oResult, 32'd2);

    // Valid together with flush in IDLE: no stall and no accept.
    @(negedge clk);
    iValid = 1'b1;
    iFlush = 1'b1;
    iOp    = OP_MUL;
    iA     = 32'd2;
    iB     = 32'd2;
    #1;
    checkOutput("flush idle stall", {31'd0, oStall}, 32'd0);
    @(negedge clk);
    iValid = 1'b0;
    iFlush = 1'b0;
    #1;
    checkOutput("flush idle no accept", {31'd0, oStall}, 32'd0);

    // Reset at RUN cycle 5: outputs clear immediately.
    @(negedge clk);
    iValid = 1'b1;
    iOp    = OP_MUL;
    iA     = 32'd5;
    iB     = 32'd6;
    repeat (5) @(negedge clk);
    #1;
    checkOutput("pre-reset stall", {31'd0, oStall}, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("mid reset stall", {31'd0, oStall}, 32'd0);
    checkOutput("mid reset done", {31'd0, oDone}, 32'd0);
    checkOutput("mid reset result", oResult, 32'd0);
    @(negedge clk);
    rst    = 1'b0;
    iValid = 1'b0;
    applyStimulus("MUL 3*4 after reset", OP_MUL, 32'd3, 32'd4, 32'd12, 33, 33);

    @(negedge clk);
    iValid = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
